// File: rtl/mem_arbiter.sv
// Shares one multicycle main memory between I-cache fills and D-cache fills/writes.
// Round-robin arbitration, block-fill address sequencing and beat steering.
module mem_arbiter #(
   parameter int unsigned WORDS_PER_BLOCK = 8,
   parameter int unsigned MEM_LATENCY     = 4,
   parameter int unsigned ADDR_W          = 16
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               i_req,
   input  logic [ADDR_W-1:0]                  i_addr,
   output logic                               i_grant,
   output logic [15:0]                        i_data,
   output logic                               i_data_valid,
   output logic [$clog2(WORDS_PER_BLOCK)-1:0] i_word_idx,
   output logic                               i_done,
   input  logic                               d_req,
   input  logic                               d_wr,
   input  logic [ADDR_W-1:0]                  d_addr,
   input  logic [15:0]                        d_wdata,
   output logic                               d_grant,
   output logic [15:0]                        d_data,
   output logic                               d_data_valid,
   output logic [$clog2(WORDS_PER_BLOCK)-1:0] d_word_idx,
   output logic                               d_done,
   output logic [ADDR_W-1:0]                  mem_addr,
   output logic [15:0]                        mem_data_in,
   output logic                               mem_enable,
   output logic                               mem_wr,
   input  logic [15:0]                        mem_data_out,
   input  logic                               mem_data_valid
);

   localparam int unsigned IdxW = $clog2(WORDS_PER_BLOCK);
   localparam int unsigned OffW = $clog2(2 * WORDS_PER_BLOCK);
   localparam logic [ADDR_W-1:0] BaseMask  = ~ADDR_W'((1 << OffW) - 1);
   localparam logic [IdxW:0]     IssueMax  = (IdxW + 1)'(WORDS_PER_BLOCK);
   localparam logic [IdxW-1:0]   RecvLast  = IdxW'(WORDS_PER_BLOCK - 1);

   if (MEM_LATENCY == 0 || WORDS_PER_BLOCK < 2 ||
       (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) begin : g_param_check
      $error("mem_arbiter: unsupported WORDS_PER_BLOCK/MEM_LATENCY");
   end

   typedef enum logic [1:0] {StIdle, StIFill, StDFill, StDWrite} state_e;

   state_e            state_q, state_d;
   logic [IdxW:0]     issue_q, issue_d;
   logic [IdxW-1:0]   recv_q, recv_d;
   logic              last_d_q, last_d_d;   // 1 when D held the most recent grant
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       wdata_q, wdata_d;

   logic              fill_active;
   logic              fill_done;
   logic [15:0]       beat_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         issue_q  <= '0;
         recv_q   <= '0;
         last_d_q <= 1'b1;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         issue_q  <= issue_d;
         recv_q   <= recv_d;
         last_d_q <= last_d_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
      end
   end

   assign fill_active = (state_q == StIFill) || (state_q == StDFill);
   assign fill_done   = fill_active && mem_data_valid && (recv_q == RecvLast);
   assign beat_data   = mem_data_valid ? mem_data_out : 16'h0000;

   // Next-state: arbitration in IDLE, issue/receive counting during fills.
   always_comb begin
      state_d  = state_q;
      issue_d  = issue_q;
      recv_d   = recv_q;
      last_d_d = last_d_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;

      unique case (state_q)
         StIdle: begin
            issue_d = '0;
            recv_d  = '0;
            if (i_req && (!d_req || last_d_q)) begin
               state_d  = StIFill;
               addr_d   = i_addr & BaseMask;
               last_d_d = 1'b0;
            end else if (d_req) begin
               state_d  = d_wr ? StDWrite : StDFill;
               addr_d   = d_wr ? d_addr : (d_addr & BaseMask);
               wdata_d  = d_wdata;
               last_d_d = 1'b1;
            end
         end
         StIFill, StDFill: begin
            if (issue_q < IssueMax) begin
               issue_d = issue_q + 1'b1;
            end
            if (mem_data_valid) begin
               recv_d = recv_q + 1'b1;
            end
            if (fill_done) begin
               state_d = StIdle;
               issue_d = '0;
               recv_d  = '0;
            end
         end
         StDWrite: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs: all gated by the current state so idle/stray beats never leak out.
   always_comb begin
      i_grant      = 1'b0;
      i_data       = '0;
      i_data_valid = 1'b0;
      i_word_idx   = '0;
      i_done       = 1'b0;
      d_grant      = 1'b0;
      d_data       = '0;
      d_data_valid = 1'b0;
      d_word_idx   = '0;
      d_done       = 1'b0;
      mem_addr     = '0;
      mem_data_in  = '0;
      mem_enable   = 1'b0;
      mem_wr       = 1'b0;

      if (fill_active && (issue_q < IssueMax)) begin
         mem_enable = 1'b1;
         mem_addr   = addr_q + ADDR_W'({issue_q[IdxW-1:0], 1'b0});
      end

      unique case (state_q)
         StIFill: begin
            i_grant      = 1'b1;
            i_data       = beat_data;
            i_data_valid = mem_data_valid;
            i_word_idx   = recv_q;
            i_done       = fill_done;
         end
         StDFill: begin
            d_grant      = 1'b1;
            d_data       = beat_data;
            d_data_valid = mem_data_valid;
            d_word_idx   = recv_q;
            d_done       = fill_done;
         end
         StDWrite: begin
            d_grant     = 1'b1;
            d_done      = 1'b1;
            mem_enable  = 1'b1;
            mem_wr      = 1'b1;
            mem_addr    = addr_q;
            mem_data_in = wdata_q;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency in-order memory model.
module tb_mem_arbiter;

   localparam int unsigned WPB = 8;
   localparam int unsigned LAT = 4;
   localparam int unsigned AW  = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_req, d_req, d_wr;
   logic [15:0] i_addr, d_addr, d_wdata;
   logic        i_grant, i_data_valid, i_done;
   logic        d_grant, d_data_valid, d_done;
   logic [15:0] i_data, d_data;
   logic [2:0]  i_word_idx, d_word_idx;
   logic [15:0] mem_addr, mem_data_in, mem_data_out;
   logic        mem_enable, mem_wr, mem_data_valid;
   logic        stray;

   int total = 0;
   int bad   = 0;

   mem_arbiter #(
      .WORDS_PER_BLOCK (WPB),
      .MEM_LATENCY     (LAT),
      .ADDR_W          (AW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_req          (i_req),
      .i_addr         (i_addr),
      .i_grant        (i_grant),
      .i_data         (i_data),
      .i_data_valid   (i_data_valid),
      .i_word_idx     (i_word_idx),
      .i_done         (i_done),
      .d_req          (d_req),
      .d_wr           (d_wr),
      .d_addr         (d_addr),
      .d_wdata        (d_wdata),
      .d_grant        (d_grant),
      .d_data         (d_data),
      .d_data_valid   (d_data_valid),
      .d_word_idx     (d_word_idx),
      .d_done         (d_done),
      .mem_addr       (mem_addr),
      .mem_data_in    (mem_data_in),
      .mem_enable     (mem_enable),
      .mem_wr         (mem_wr),
      .mem_data_out   (mem_data_out),
      .mem_data_valid (mem_data_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_fn(input logic [15:0] a);
      return a ^ 16'h5A5A;
   endfunction

   // Read issued in cycle t returns in cycle t+LAT; the model ignores reset on purpose.
   logic [LAT-1:0] pv = '0;
   logic [15:0]    pd [LAT];
   always @(posedge clk) begin
      pv    <= {pv[LAT-2:0], mem_enable & ~mem_wr};
      pd[0] <= mem_fn(mem_addr);
      for (int k = 1; k < LAT; k++) pd[k] <= pd[k-1];
   end
   assign mem_data_valid = pv[LAT-1] | stray;
   assign mem_data_out   = stray ? 16'hDEAD : pd[LAT-1];

   wire any_out = |{i_grant, i_data, i_data_valid, i_word_idx, i_done,
                    d_grant, d_data, d_data_valid, d_word_idx, d_done,
                    mem_addr, mem_data_in, mem_enable, mem_wr};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called at cycle 0 of a fill; returns at cycle 11 (the done cycle).
   task automatic check_fill(input bit is_i, input logic [15:0] base);
      logic [15:0] ea;
      for (int c = 0; c < 12; c++) begin
         chk("grant", 32'(is_i ? i_grant : d_grant), 32'd1);
         chk("other_side_idle", is_i ? 32'({d_grant, d_data_valid, d_done, d_word_idx, d_data})
                                     : 32'({i_grant, i_data_valid, i_done, i_word_idx, i_data}),
             32'd0);
         chk("mem_enable", 32'(mem_enable), 32'(c < 8));
         chk("mem_wr_data_in", 32'({mem_wr, mem_data_in}), 32'd0);
         if (c < 8) begin
            ea = base + 16'(2 * c);
            chk("mem_addr", 32'(mem_addr), 32'(ea));
         end
         chk("beat_valid", 32'(is_i ? i_data_valid : d_data_valid), 32'(c >= 4));
         if (c >= 4) begin
            ea = base + 16'(2 * (c - 4));
            chk("word_idx", 32'(is_i ? i_word_idx : d_word_idx), 32'(c - 4));
            chk("beat_data", 32'(is_i ? i_data : d_data), 32'(mem_fn(ea)));
         end else begin
            chk("data_gated", 32'(is_i ? i_data : d_data), 32'd0);
         end
         chk("done", 32'(is_i ? i_done : d_done), 32'(c == 11));
         if (c < 11) step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; stray = 1'b0;
      i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
      step(); step();
      chk("reset_outputs", 32'(any_out), 32'd0);
      rst_n = 1'b1;
      step();
      chk("idle_outputs", 32'(any_out), 32'd0);

      // I fill alone.
      i_req = 1'b1; i_addr = 16'h1236;
      step();
      check_fill(1'b1, 16'h1230);
      i_req = 1'b0;
      step();
      chk("idle_after_i", 32'(any_out), 32'd0);

      // Simultaneous requests out of reset: I first, then D after one idle cycle.
      rst_n = 1'b0; step(); rst_n = 1'b1;
      i_req = 1'b1; i_addr = 16'h2000;
      d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h3458;
      step();
      check_fill(1'b1, 16'h2000);
      i_req = 1'b0;
      step();
      chk("idle_gap_id", 32'({i_grant, d_grant, mem_enable}), 32'd0);
      step();
      check_fill(1'b0, 16'h3450);

      // Both held: grants alternate I, D, I, D.
      i_req = 1'b1; i_addr = 16'h4002;
      d_req = 1'b1; d_addr = 16'h501F;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("idle_gap_rr", 32'({i_grant, d_grant, mem_enable}), 32'd0);
         step();
         check_fill((k % 2) == 0, ((k % 2) == 0) ? 16'h4000 : 16'h5010);
      end

      // D write; inputs changed after grant must not matter.
      i_req = 1'b0;
      d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0040; d_wdata = 16'hBEEF;
      step();
      chk("idle_before_wr", 32'({i_grant, d_grant, mem_enable}), 32'd0);
      step();
      d_wdata = 16'h1111; d_addr = 16'h0F00;
      #1;
      chk("wr_ctl", 32'({d_grant, d_done, mem_enable, mem_wr, i_grant}), 32'b11110);
      chk("wr_addr", 32'(mem_addr), 32'h0040);
      chk("wr_data", 32'(mem_data_in), 32'hBEEF);
      stray = 1'b1;
      #1;
      chk("stray_in_write", 32'({i_data_valid, d_data_valid, d_data}), 32'd0);
      stray = 1'b0;
      d_req = 1'b0; d_wr = 1'b0;
      step();
      chk("after_wr", 32'(any_out), 32'd0);

      // Reset at cycle 6 of an I fill; in-flight beats must be ignored.
      i_req = 1'b1; i_addr = 16'h1236;
      step();
      for (int c = 0; c < 6; c++) begin
         chk("pre_rst_grant", 32'({i_grant, mem_enable}), 32'b11);
         step();
      end
      rst_n = 1'b0; i_req = 1'b0;
      #1;
      chk("rst_async_outs", 32'(any_out), 32'd0);
      step();
      rst_n = 1'b1;
      for (int c = 7; c < 11; c++) begin
         chk("late_beats_ignored", 32'(any_out), 32'd0);
         if (c < 10) step();
      end
      i_req = 1'b1; i_addr = 16'h1236;
      step();
      check_fill(1'b1, 16'h1230);
      i_req = 1'b0;
      step();

      // Stray valid in IDLE, across a clock edge, then a clean fill.
      stray = 1'b1;
      #1;
      chk("stray_idle", 32'(any_out), 32'd0);
      step();
      chk("stray_idle_2", 32'(any_out), 32'd0);
      stray = 1'b0;
      i_req = 1'b1; i_addr = 16'h7778;
      step();
      check_fill(1'b1, 16'h7770);
      i_req = 1'b0;
      step();
      chk("final_idle", 32'(any_out), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single multicycle main memory between the instruction-cache miss path and the data-cache miss/write path.
- Sequences block fills: one address per cycle for a whole cache block, then counts returning data beats and steers each beat to the granted cache with a word index.
- Arbitrates simultaneous requests round-robin so neither cache starves.
- Issues single-word data-cache writes directly to memory.

Parameters:
- WORDS_PER_BLOCK, 8, 16-bit words per cache block; power of two.
- MEM_LATENCY, 4, cycles from address issue to the matching mem_data_valid beat.
- ADDR_W, 16, byte-address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_req  in  1  I-cache miss; held high until i_done.
- i_addr  in  ADDR_W  I-cache miss byte address.
- i_grant  out  1  I fill in progress.
- i_data  out  16  fill data to I-cache.
- i_data_valid  out  1  i_data beat valid.
- i_word_idx  out  log2(WORDS_PER_BLOCK)  word index of the current I beat.
- i_done  out  1  one-cycle pulse on the final I beat.
- d_req  in  1  D-cache request; held high until d_done.
- d_wr  in  1  1 = single-word write, 0 = block fill.
- d_addr  in  ADDR_W  D byte address.
- d_wdata  in  16  write data.
- d_grant  out  1  D fill or write in progress.
- d_data  out  16  fill data to D-cache.
- d_data_valid  out  1  d_data beat valid.
- d_word_idx  out  log2(WORDS_PER_BLOCK)  word index of the current D beat.
- d_done  out  1  one-cycle pulse on the final D beat, or in the write cycle.
- mem_addr  out  ADDR_W  memory address.
- mem_data_in  out  16  memory write data.
- mem_enable  out  1  memory access this cycle.
- mem_wr  out  1  memory write strobe.
- mem_data_out  in  16  memory read data.
- mem_data_valid  in  1  read data valid.

Behaviour:
- Reset (asynchronous, rst_n low):
  - FSM goes to IDLE; issue and receive counters clear to 0.
  - Every output is 0.
  - last_grant clears to D, so I wins the first tie.
- FSM states: IDLE, IFILL, DFILL, DWRITE.
- IDLE arbitration:
  - Only i_req pending -> IFILL.
  - Only d_req pending -> DWRITE if d_wr, else DFILL.
  - Both pending -> the side not equal to last_grant wins.
  - last_grant updates on every grant.
  - No request -> stay in IDLE.
- Latching at grant:
  - Fill base = addr with low log2(2*WORDS_PER_BLOCK) bits cleared.
  - d_wdata is latched for writes.
  - Later input changes are ignored until done.
- Grant outputs: i_grant/d_grant are registered and high for every cycle spent in the corresponding state.
- FILL issue phase:
  - For WORDS_PER_BLOCK consecutive cycles starting with the first FILL cycle, drive mem_enable=1, mem_wr=0, mem_addr = base + 2*issue_cnt.
  - issue_cnt increments each issue cycle and saturates; after that mem_enable=0.
- FILL receive phase:
  - Memory contract: address issued in cycle t returns mem_data_valid in cycle t+MEM_LATENCY, in order.
  - x_data = mem_data_out and x_data_valid = mem_data_valid, both combinational, gated by the matching state.
  - x_word_idx = recv_cnt; recv_cnt increments on each valid beat.
- FILL completion:
  - On the beat where recv_cnt = WORDS_PER_BLOCK-1, pulse x_done (combinational with that beat).
  - Next state is IDLE; counters clear.
  - Defaults give an 8-beat fill occupying 12 cycles; first beat arrives in cycle 4 of the state, done in cycle 11.
- DWRITE: one cycle, mem_enable=1, mem_wr=1, mem_addr=d_addr (latched), mem_data_in=d_wdata, d_done=1; next state is IDLE.
- Idle cycle: a new grant can occur in the cycle after done, so one IDLE cycle minimum separates transactions.
- Request dropped mid-fill: the fill completes anyway; beats and done are still produced.
- Stray mem_data_valid in IDLE or DWRITE: ignored; no data_valid output, no counter change.
- Reset mid-fill: immediate return to IDLE; beats arriving after reset release are ignored.
- Unused outputs: mem_data_in is 0 except in DWRITE; x_data is 0 when its x_data_valid is 0.

Test Plan:
- I fill alone, i_addr=0x1236:
  - mem_addr 0x1230,0x1232,...,0x123E on cycles 0-7.
  - Memory model returns beats cycles 4-11; i_word_idx 0..7; i_done at cycle 11.
  - i_grant high cycles 0-11; d_* stay 0.
- Simultaneous i_req and d_req (fill) out of reset:
  - I granted first.
  - After i_done plus one IDLE cycle, D fill runs with d_addr base; d_word_idx 0..7 in order.
- Both requesters held continuously across 4 transactions -> grants alternate I,D,I,D.
- D write, d_addr=0x0040, d_wdata=0xBEEF -> single cycle with mem_enable=1, mem_wr=1, mem_addr=0x0040, mem_data_in=0xBEEF, d_done=1.
- Reset mid-fill: assert rst_n=0 at cycle 6 of an I fill, release, keep requests low.
  - All outputs 0 immediately.
  - Late mem_data_valid pulses produce no i_data_valid; next i_req starts a fresh fill at idx 0.
- mem_data_valid pulsed while IDLE -> no data_valid output; a subsequent fill still reports word indices 0..7.
